// File: rtl/muldiv_seq.sv
// Purpose: sequential 32x32 unsigned multiplier / restoring divider for the EXE stage (MULTU, DIVU).
// Latency: 33 cycles from the start-sampling edge to done; 1 cycle for a zero divisor.
// Backpressure: stall holds IF/ID/EXE while an op runs; start is ignored unless IDLE; flush aborts.
// Optional divider: define MULDIV_SEQ_DIV_EN to build the DIV path; otherwise DIVU is a reserved op.
module muldiv_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MUL   = 2'd1;
`ifdef MULDIV_SEQ_DIV_EN
  localparam logic [1:0] DIV   = 2'd2;
`endif
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;

  logic [1:0]  state;
  logic [4:0]  cnt;
  // acc_hi/acc_lo: partial product (mul) or remainder/quotient-shift pair (div)
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  // opb: multiplicand for MUL, divisor for DIV
  logic [31:0] opb;
  logic        op_valid;

  logic [32:0] mul_sum;
  logic [31:0] mul_hi_n;
  logic [31:0] mul_lo_n;

  // One shift-add multiply step: add multiplicand when the low bit is set, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
    mul_hi_n = mul_sum[32:1];
    mul_lo_n = {mul_sum[0], acc_lo[31:1]};
  end

`ifdef MULDIV_SEQ_DIV_EN
  logic        div_en_unused;
  logic [32:0] div_r;
  logic [32:0] div_t;
  logic [31:0] div_hi_n;
  logic [31:0] div_lo_n;

  // One restoring divide step: shift in the next dividend bit, keep the difference if non-negative.
  always_comb begin
    div_r    = {acc_hi, acc_lo[31]};
    div_t    = div_r - {1'b0, opb};
    div_hi_n = div_t[32] ? div_r[31:0] : div_t[31:0];
    div_lo_n = {acc_lo[30:0], ~div_t[32]};
  end
  assign div_en_unused = 1'b0;
  assign op_valid = (op == OP_MULTU) || (op == OP_DIVU);
`else
  assign op_valid = (op == OP_MULTU);
`endif

  logic dbz_q;

  // Status outputs; flush masks the done/dbz pulse in the cycle it is asserted.
  always_comb begin
    busy  = (state != IDLE);
    stall = (state == MUL)
`ifdef MULDIV_SEQ_DIV_EN
          || (state == DIV)
`endif
          || ((state == IDLE) && start && op_valid);
    done  = (state == DONE) && !flush;
    dbz   = dbz_q && (state == DONE) && !flush;
  end

  // FSM, iteration datapath and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      opb    <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      dbz_q  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= 5'd0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (op == OP_MULTU)) begin
            acc_hi <= 32'd0;
            acc_lo <= b;
            opb    <= a;
            cnt    <= 5'd31;
            state  <= MUL;
          end
`ifdef MULDIV_SEQ_DIV_EN
          else if (start && (op == OP_DIVU)) begin
            if (b == 32'd0) begin
              hi    <= a;
              lo    <= 32'hFFFF_FFFF;
              dbz_q <= 1'b1;
              state <= DONE;
            end else begin
              acc_hi <= 32'd0;
              acc_lo <= a;
              opb    <= b;
              cnt    <= 5'd31;
              state  <= DIV;
            end
          end
`endif
        end
        MUL: begin
          acc_hi <= mul_hi_n;
          acc_lo <= mul_lo_n;
          cnt    <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            hi    <= mul_hi_n;
            lo    <= mul_lo_n;
            dbz_q <= 1'b0;
            state <= DONE;
          end
        end
`ifdef MULDIV_SEQ_DIV_EN
        DIV: begin
          acc_hi <= div_hi_n;
          acc_lo <= div_lo_n;
          cnt    <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            hi    <= div_hi_n;
            lo    <= div_lo_n;
            dbz_q <= div_en_unused;
            state <= DONE;
          end
        end
`endif
        DONE: begin
          dbz_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: table of operations plus flush, busy-start and reset sequences.
module tb_muldiv_seq;

`ifdef MULDIV_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        stall, busy, done, dbz;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;

  muldiv_seq dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t v[11];
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Present one start request in cycle 0 and check the combinational stall.
  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv, input logic exp_stall);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    #1 chk("stall_cycle0", {63'd0, stall}, {63'd0, exp_stall});
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Wait up to 40 cycles for done; optionally inject a stray start at cycle inj.
  task automatic wait_done(input int inj, output int lat, output int stalls,
                           output logic [31:0] rhi, output logic [31:0] rlo,
                           output logic rdbz, output logic rstall);
    lat = 0; stalls = 0; rhi = 32'd0; rlo = 32'd0; rdbz = 1'b0; rstall = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = n; rhi = hi; rlo = lo; rdbz = dbz; rstall = stall;
        break;
      end
      if (stall) stalls++;
      if (n == inj) begin start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd7; end
    end
    start = 1'b0;
  endtask

  int lat, stalls;
  logic [31:0] rhi, rlo;
  logic rdbz, rstall, valid;

  initial begin
    v[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
    v[1]  = '{2'b00, 32'd3,        32'd5,        32'h00000000, 32'd15,       1'b0, 33};
    v[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    v[3]  = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33};
    v[4]  = '{2'b00, 32'd0,        32'd1234,     32'h00000000, 32'h00000000, 1'b0, 33};
    v[5]  = '{2'b01, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
    v[6]  = '{2'b01, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 1};
    v[7]  = '{2'b01, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 33};
    v[8]  = '{2'b01, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0, 33};
    v[9]  = '{2'b11, 32'd9,        32'd9,        32'd0,        32'd0,        1'b0, 0};
    v[10] = '{2'b10, 32'd9,        32'd9,        32'd0,        32'd0,        1'b0, 0};

    // Reset state, checked before any clock edge
    #3;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_flags", {60'd0, done, dbz, busy, stall}, 64'd0);
    #9 resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      valid = (v[i].op == 2'b00) || ((v[i].op == 2'b01) && DIV_EN);
      issue(v[i].op, v[i].a, v[i].b, valid);
      wait_done(0, lat, stalls, rhi, rlo, rdbz, rstall);
      if (valid) begin
        chk($sformatf("v%0d_lat", i), lat, v[i].lat);
        chk($sformatf("v%0d_hi", i), {32'd0, rhi}, {32'd0, v[i].hi});
        chk($sformatf("v%0d_lo", i), {32'd0, rlo}, {32'd0, v[i].lo});
        chk($sformatf("v%0d_dbz", i), {63'd0, rdbz}, {63'd0, v[i].dbz});
        chk($sformatf("v%0d_stalls", i), stalls, v[i].lat - 1);
        chk($sformatf("v%0d_stall_done", i), {63'd0, rstall}, 64'd0);
        @(negedge clk);
        chk($sformatf("v%0d_after", i), {61'd0, done, dbz, busy}, 64'd0);
        last_hi = v[i].hi; last_lo = v[i].lo;
      end else begin
        chk($sformatf("v%0d_nodone", i), lat, 0);
        chk($sformatf("v%0d_nostall", i), stalls, 0);
        chk($sformatf("v%0d_hold", i), {hi, lo}, {last_hi, last_lo});
        chk($sformatf("v%0d_idle", i), {62'd0, busy, dbz}, 64'd0);
      end
    end

    // Stray start while busy is ignored; result and latency unaffected, nothing queued
    issue(2'b00, 32'd3, 32'd5, 1'b1);
    wait_done(5, lat, stalls, rhi, rlo, rdbz, rstall);
    chk("busy_start_lat", lat, 33);
    chk("busy_start_res", {rhi, rlo}, 64'd15);
    last_hi = 32'd0; last_lo = 32'd15;
    repeat (3) @(negedge clk);
    chk("busy_start_noqueue", {62'd0, busy, done}, 64'd0);

    // Flush mid-multiply at cycle 10
    issue(2'b00, 32'h0000FFFF, 32'h0000FFFF, 1'b1);
    repeat (9) @(negedge clk);
    chk("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {62'd0, busy, stall}, 64'd0);
    wait_done(0, lat, stalls, rhi, rlo, rdbz, rstall);
    chk("flush_nodone", lat, 0);
    chk("flush_hold", {hi, lo}, {last_hi, last_lo});

    // Flush and start together in IDLE: stall still follows start, nothing begins
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2; flush = 1'b1;
    #1 chk("flush_start_stall", {63'd0, stall}, 64'd1);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_idle", {62'd0, busy, stall}, 64'd0);

    // Reset mid-operation at cycle 20
    issue(DIV_EN ? 2'b01 : 2'b00, 32'd100, 32'd7, 1'b1);
    repeat (19) @(negedge clk);
    chk("rst_mid_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_out", {hi, lo}, 64'd0);
    chk("rst_mid_flags", {60'd0, done, dbz, busy, stall}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    wait_done(0, lat, stalls, rhi, rlo, rdbz, rstall);
    chk("rst_mid_nodone", lat, 0);
    chk("rst_mid_idle", {63'd0, busy}, 64'd0);
    issue(2'b11, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    chk("rst_reserved_idle", {63'd0, busy}, 64'd0);

    // Normal operation after reset release
    issue(2'b00, 32'hFFFFFFFF, 32'h00000002, 1'b1);
    wait_done(0, lat, stalls, rhi, rlo, rdbz, rstall);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_res", {rhi, rlo}, 64'h00000001_FFFFFFFE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
